// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Imported by the arbiter, its counter sub-module and the bench.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT_IF = 2'd1,
      GRANT_D  = 2'd2,
      TURN     = 2'd3
   } arb_state_e;

   typedef enum logic {
      TAG_IF = 1'b0,
      TAG_D  = 1'b1
   } tag_e;

   localparam int CNT_W = 16;

   // Bits needed to hold values 0..max inclusive (at least one).
   function automatic int cnt_width(input int max);
      int w;
      w = $clog2(max + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side signals of the port arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic [DATA_W-1:0] if_rdata;
   logic              if_rvalid;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic [DATA_W-1:0] d_rdata;
   logic              d_rvalid;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wren;
   logic              mem_rden;
   logic [DATA_W-1:0] mem_q;

   modport slave (
      input  if_req,
      input  if_addr,
      output if_gnt,
      output if_rdata,
      output if_rvalid,
      input  d_req,
      input  d_we,
      input  d_addr,
      input  d_wdata,
      output d_gnt,
      output d_rdata,
      output d_rvalid,
      output mem_addr,
      output mem_wdata,
      output mem_wren,
      output mem_rden,
      input  mem_q
   );

   modport master (
      output if_req,
      output if_addr,
      input  if_gnt,
      input  if_rdata,
      input  if_rvalid,
      output d_req,
      output d_we,
      output d_addr,
      output d_wdata,
      input  d_gnt,
      input  d_rdata,
      input  d_rvalid,
      input  mem_addr,
      input  mem_wdata,
      input  mem_wren,
      input  mem_rden,
      output mem_q
   );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment in the same cycle.
module sat_counter #(
   parameter int W   = 2,
   parameter int MAX = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] CMAX = W'(MAX);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CMAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous single-port memory between fetch
// and load/store; D wins unless fetch has waited MAX_D_STREAK grants.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 8,
   parameter int MAX_D_STREAK = 3,
   parameter int WR_TURN      = 1
) (
   input  logic              clock,
   input  logic              reset,
   mem_port_arbiter_if.slave bus,
   output logic              stall_if,
   output logic [CNT_W-1:0]  conflict_cnt
);

   localparam int SW = cnt_width(MAX_D_STREAK);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
   localparam bit USE_TURN = (WR_TURN != 0);

   arb_state_e state_q, state_d;
   logic       pend_q, pend_d;
   tag_e       tag_q, tag_d;

   logic [DATA_W-1:0] if_hold_q, if_hold_d;
   logic [DATA_W-1:0] d_hold_q, d_hold_d;
   logic [CNT_W-1:0]  conf_q, conf_d;

   logic [SW-1:0] streak;
   logic          force_if;
   logic          d_win;
   logic          if_win;
   logic          gnt_if;
   logic          gnt_d;
   logic          rv_if;
   logic          rv_d;

   assign force_if = bus.if_req && (streak == STREAK_MAX);
   assign d_win    = bus.d_req && !force_if;
   assign if_win   = bus.if_req && !d_win;

   always_comb begin
      gnt_if  = 1'b0;
      gnt_d   = 1'b0;
      state_d = IDLE;
      // Reset and the post-write turnaround both block every grant.
      if (reset && (state_q != TURN)) begin
         gnt_d  = d_win;
         gnt_if = if_win;
      end
      if (gnt_d) begin
         state_d = (bus.d_we && USE_TURN) ? TURN : GRANT_D;
      end else if (gnt_if) begin
         state_d = GRANT_IF;
      end
   end

   sat_counter #(
      .W   (SW),
      .MAX (MAX_D_STREAK)
   ) u_streak (
      .clk_i  (clock),
      .rst_ni (reset),
      .clr_i  (gnt_if || !bus.if_req),
      .inc_i  (gnt_d && bus.if_req),
      .cnt_o  (streak)
   );

   assign bus.if_gnt    = gnt_if;
   assign bus.d_gnt     = gnt_d;
   assign bus.mem_wren  = gnt_d && bus.d_we;
   assign bus.mem_rden  = gnt_if || (gnt_d && !bus.d_we);
   assign bus.mem_wdata = reset ? bus.d_wdata : '0;

   always_comb begin
      bus.mem_addr = '0;
      unique case (1'b1)
         gnt_d:   bus.mem_addr = bus.d_addr;
         gnt_if:  bus.mem_addr = bus.if_addr;
         default: bus.mem_addr = '0;
      endcase
   end

   assign pend_d = bus.mem_rden;
   assign tag_d  = gnt_d ? TAG_D : TAG_IF;

   assign rv_if = pend_q && (tag_q == TAG_IF);
   assign rv_d  = pend_q && (tag_q == TAG_D);

   // Returning data is forwarded straight from mem_q, then held.
   assign if_hold_d = rv_if ? bus.mem_q : if_hold_q;
   assign d_hold_d  = rv_d ? bus.mem_q : d_hold_q;

   assign bus.if_rvalid = rv_if;
   assign bus.d_rvalid  = rv_d;
   assign bus.if_rdata  = if_hold_d;
   assign bus.d_rdata   = d_hold_d;

   assign stall_if = reset && bus.if_req && !gnt_if;

   assign conf_d = conf_q + CNT_W'(bus.if_req && bus.d_req);
   assign conflict_cnt = conf_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         pend_q    <= 1'b0;
         tag_q     <= TAG_IF;
         if_hold_q <= '0;
         d_hold_q  <= '0;
         conf_q    <= '0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         tag_q     <= tag_d;
         if_hold_q <= if_hold_d;
         d_hold_q  <= d_hold_d;
         conf_q    <= conf_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random and directed
// traffic checked against a cycle-level model of the sharing rules.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW   = 8;
   localparam int DW   = 8;
   localparam int MAXS = 3;
   localparam int WRT  = 1;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_if;
   logic [15:0] conflict_cnt;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   mem_port_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .MAX_D_STREAK (MAXS),
      .WR_TURN      (WRT)
   ) u_dut (
      .clock        (clk),
      .reset        (rst_n),
      .bus          (bus),
      .stall_if     (stall_if),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   logic [7:0] mem_arr [256];
   logic [7:0] ref_mem [256];

   always @(posedge clk) begin
      if (bus.mem_wren) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rden) bus.mem_q <= mem_arr[bus.mem_addr];
   end

   int total = 0;
   int bad = 0;
   int cyc = 0;

   exp_t ifq[$];
   exp_t dq[$];
   logic [7:0]  hold_if = 8'h00;
   logic [7:0]  hold_d = 8'h00;
   int          m_streak = 0;
   bit          m_turn = 1'b0;
   logic [15:0] m_conf = 16'h0000;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (cyc > 90000) begin
         $display("FAIL watchdog cycle budget exceeded cyc=%0d", cyc);
         $fatal(1);
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
      end
   endtask

   // One request cycle: drive, predict grants, queue expected reads.
   task automatic cycle(input bit ir, input logic [7:0] ia,
                        input bit dr, input bit dwe,
                        input logic [7:0] da, input logic [7:0] dd,
                        output bit gi, output bit gd);
      bit         e_if;
      bit         e_d;
      logic [7:0] e_addr;
      @(negedge clk);
      bus.if_req  = ir;
      bus.if_addr = ia;
      bus.d_req   = dr;
      bus.d_we    = dwe;
      bus.d_addr  = da;
      bus.d_wdata = dd;
      #1;
      e_if = 1'b0;
      e_d  = 1'b0;
      if (!m_turn) begin
         if (dr && !(ir && m_streak == MAXS)) e_d = 1'b1;
         else if (ir) e_if = 1'b1;
      end
      e_addr = e_d ? da : (e_if ? ia : 8'h00);
      gi = bus.if_gnt;
      gd = bus.d_gnt;
      chk("if_gnt", 32'(gi), 32'(e_if));
      chk("d_gnt", 32'(gd), 32'(e_d));
      chk("stall_if", 32'(stall_if), 32'(ir && !e_if));
      chk("mem_wren", 32'(bus.mem_wren), 32'(e_d && dwe));
      chk("mem_rden", 32'(bus.mem_rden), 32'(e_if || (e_d && !dwe)));
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      if (e_d && dwe) chk("mem_wdata", 32'(bus.mem_wdata), 32'(dd));
      if (e_if) ifq.push_back('{data: ref_mem[ia], due: cyc + 1});
      if (e_d && !dwe) dq.push_back('{data: ref_mem[da], due: cyc + 1});
      if (e_d && dwe) ref_mem[da] = dd;
      if (ir && dr) m_conf = m_conf + 16'd1;
      m_turn = e_d && dwe && (WRT != 0);
      if (e_if || !ir) m_streak = 0;
      else if (e_d && m_streak < MAXS) m_streak++;
   endtask

   task automatic quiet_inputs();
      bus.if_req  = 1'b0;
      bus.if_addr = 8'h00;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 8'h00;
      bus.d_wdata = 8'h00;
   endtask

   // Assert reset now, check the cleared outputs, release n cycles later.
   task automatic do_reset(input int n);
      rst_n = 1'b0;
      #1;
      ifq.delete();
      dq.delete();
      hold_if  = 8'h00;
      hold_d   = 8'h00;
      m_streak = 0;
      m_turn   = 1'b0;
      m_conf   = 16'h0000;
      chk("rst_gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'd0);
      chk("rst_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
      chk("rst_rdata", 32'({bus.if_rdata, bus.d_rdata}), 32'd0);
      chk("rst_mem_en", 32'({bus.mem_wren, bus.mem_rden}), 32'd0);
      chk("rst_mem_bus", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
      chk("rst_stall", 32'(stall_if), 32'd0);
      chk("rst_conflict", 32'(conflict_cnt), 32'd0);
      chk("rst_state", 32'(u_dut.state_q), 32'(IDLE));
      quiet_inputs();
      repeat (n) @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (ifq.size() > 0 && ifq[0].due == cyc) begin
            chk("if_rvalid", 32'(bus.if_rvalid), 32'd1);
            chk("if_rdata", 32'(bus.if_rdata), 32'(ifq[0].data));
            hold_if = ifq[0].data;
            void'(ifq.pop_front());
         end else begin
            chk("if_rvalid_idle", 32'(bus.if_rvalid), 32'd0);
            chk("if_rdata_hold", 32'(bus.if_rdata), 32'(hold_if));
         end
         if (dq.size() > 0 && dq[0].due == cyc) begin
            chk("d_rvalid", 32'(bus.d_rvalid), 32'd1);
            chk("d_rdata", 32'(bus.d_rdata), 32'(dq[0].data));
            hold_d = dq[0].data;
            void'(dq.pop_front());
         end else begin
            chk("d_rvalid_idle", 32'(bus.d_rvalid), 32'd0);
            chk("d_rdata_hold", 32'(bus.d_rdata), 32'(hold_d));
         end
         chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
      end
   end

   initial begin
      bit         gi, gd;
      bit         ir, dr, dwe;
      logic [7:0] ia, da, dd, v;
      bit         wait_if, wait_d;

      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom);
         mem_arr[i] = v;
         ref_mem[i] = v;
      end
      mem_arr[0] = 8'hA5; ref_mem[0] = 8'hA5;
      mem_arr[1] = 8'h11; ref_mem[1] = 8'h11;
      mem_arr[2] = 8'h22; ref_mem[2] = 8'h22;
      bus.mem_q = 8'h00;
      quiet_inputs();
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;

      // Random traffic; stores stay out of the directed address range.
      ir = 0; dr = 0; dwe = 0; ia = 0; da = 0; dd = 0;
      wait_if = 0; wait_d = 0;
      for (int i = 0; i < 400; i++) begin
         if (!wait_if || $urandom_range(9) == 0) begin
            ir = ($urandom_range(2) != 0);
            ia = 8'($urandom);
         end
         if (!wait_d || $urandom_range(9) == 0) begin
            dr  = ($urandom_range(2) != 0);
            dwe = ($urandom_range(3) == 0);
            da  = dwe ? 8'h40 + 8'($urandom_range(191)) : 8'($urandom);
            dd  = 8'($urandom);
         end
         cycle(ir, ia, dr, dwe, da, dd, gi, gd);
         wait_if = ir && !gi;
         wait_d  = dr && !gd;
      end

      // Reset mid-activity, then a fetch of address 0.
      @(posedge clk);
      #2;
      do_reset(2);
      cycle(1, 8'h00, 0, 0, 8'h00, 8'h00, gi, gd);
      chk("t1_if_gnt", 32'(gi), 32'd1);
      @(posedge clk);
      #1;
      chk("t1_if_rvalid", 32'(bus.if_rvalid), 32'd1);
      chk("t1_if_rdata", 32'(bus.if_rdata), 32'hA5);

      // Both requesting: three D grants, then fetch is forced.
      repeat (2) cycle(0, 8'h00, 0, 0, 8'h00, 8'h00, gi, gd);
      for (int i = 0; i < 8; i++) begin
         cycle(1, 8'h03, 1, 0, 8'h10, 8'h00, gi, gd);
         chk("t2_d_gnt", 32'(gd), 32'(i % 4 != 3));
         chk("t2_if_gnt", 32'(gi), 32'(i % 4 == 3));
      end

      // Store with turnaround while fetch waits, then read it back.
      repeat (2) cycle(0, 8'h00, 0, 0, 8'h00, 8'h00, gi, gd);
      cycle(1, 8'h05, 1, 1, 8'h20, 8'h3C, gi, gd);
      chk("t3_store_gnt", 32'({gi, gd}), 32'b01);
      cycle(1, 8'h05, 0, 0, 8'h00, 8'h00, gi, gd);
      chk("t3_turn_gnt", 32'({gi, gd}), 32'b00);
      chk("t3_turn_stall", 32'(stall_if), 32'd1);
      cycle(1, 8'h05, 0, 0, 8'h00, 8'h00, gi, gd);
      chk("t3_if_after_turn", 32'({gi, gd}), 32'b10);
      cycle(0, 8'h00, 1, 0, 8'h20, 8'h00, gi, gd);
      @(posedge clk);
      #1;
      chk("t3_load_back", 32'(bus.d_rdata), 32'h3C);

      // Back-to-back fetches alternate 0x01/0x02; d_rdata must hold.
      for (int i = 0; i < 8; i++) begin
         cycle(1, (i % 2 == 0) ? 8'h01 : 8'h02, 0, 0, 8'h00, 8'h00, gi, gd);
      end
      @(posedge clk);
      #1;
      chk("t4_d_rdata_kept", 32'(bus.d_rdata), 32'h3C);
      chk("t4_last_if", 32'(bus.if_rdata), 32'h22);

      // Read granted, then reset lands before its data is taken.
      cycle(0, 8'h00, 1, 0, 8'h01, 8'h00, gi, gd);
      @(posedge clk);
      #2;
      do_reset(2);
      cycle(0, 8'h00, 0, 0, 8'h00, 8'h00, gi, gd);
      chk("t5_no_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
      chk("t5_rdata_zero", 32'({bus.if_rdata, bus.d_rdata}), 32'd0);

      // Conflict counter wraps after 65536 conflict cycles.
      @(posedge clk);
      #2;
      do_reset(1);
      for (int i = 0; i < 65535; i++) begin
         cycle(1, 8'h00, 1, 0, 8'h10, 8'h00, gi, gd);
      end
      @(posedge clk);
      #1;
      chk("t6_cnt_max", 32'(conflict_cnt), 32'hFFFF);
      cycle(1, 8'h00, 1, 0, 8'h10, 8'h00, gi, gd);
      @(posedge clk);
      #1;
      chk("t6_cnt_wrap", 32'(conflict_cnt), 32'h0000);

      repeat (3) cycle(0, 8'h00, 0, 0, 8'h00, 8'h00, gi, gd);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous 8-bit memory between two requesters: instruction fetch (IF port) and pipeline load/store (D port).
- Lets the processor run from one unified memory instead of separate instruction and data memory instances.
- Sits between the pipeline control/datapath and the memory block.
- Produces the fetch-stall signal for the pipeline and a conflict counter for the performance display.

Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, data width
- MAX_D_STREAK, 3, consecutive D grants allowed while IF waits before IF is forced
- WR_TURN, 1, idle turnaround cycles after a write (0 or 1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address (PC)
- if_gnt  out  1  fetch accepted this cycle
- if_rdata  out  DATA_W  fetched instruction, held until next if_rvalid
- if_rvalid  out  1  if_rdata updated this cycle
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access accepted this cycle
- d_rdata  out  DATA_W  load data, held until next d_rvalid
- d_rvalid  out  1  d_rdata updated this cycle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wren  out  1  memory write enable
- mem_rden  out  1  memory read enable
- mem_q  in  DATA_W  memory read data, valid 1 cycle after mem_rden
- stall_if  out  1  if_req high and not granted
- conflict_cnt  out  16  cycles with if_req and d_req both high

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs, the streak counter, rdata holds, the pending-read tag and conflict_cnt clear to 0.
- FSM states:
  - IDLE, GRANT_IF, GRANT_D: the state reflects the current cycle's grant.
  - TURN: write turnaround.
  - The grant decision is combinational from the requests and the registered state/streak, so a grant happens in the same cycle as the request.
- Arbitration, when not in TURN:
  - D has priority.
  - Exception: if streak == MAX_D_STREAK and if_req=1, IF is granted.
  - Neither request high: next state IDLE, mem_rden=mem_wren=0.
- Streak counter:
  - Increments on each D grant while if_req=1, saturating at MAX_D_STREAK.
  - Clears on any IF grant, or on any cycle with if_req=0.
- Granted port drives memory:
  - mem_addr = granted address.
  - mem_wren = d_we on a D grant, else 0.
  - mem_rden = 1 on any read grant.
  - mem_wdata = d_wdata.
- Read latency:
  - A read granted in cycle t registers a pending tag (IF or D).
  - At t+1 the tagged rvalid pulses high for 1 cycle and its rdata register loads mem_q.
  - The other port's rdata is unchanged.
  - Back-to-back reads are fully pipelined: one grant per cycle.
- Writes:
  - d_gnt=1 and no rvalid.
  - If WR_TURN=1, the next cycle is TURN: no grants, stall_if=1 if if_req, mem enables 0. Then arbitration resumes.
  - If WR_TURN=0, TURN is skipped.
- Requester rules:
  - A requester keeps req and its address/data stable until it sees gnt.
  - Dropping req without gnt is legal; no access occurs.
- stall_if = if_req & ~if_gnt, combinational.
- conflict_cnt:
  - Increments on every cycle with if_req & d_req, TURN cycles included.
  - Wraps from 0xFFFF to 0.
- Reset mid-read: the pending tag clears and no rvalid is produced after reset release.
- Same-address store then load (WR_TURN=0): the load in the next cycle returns the new data. The memory write completes at the edge.

Decomposition:
- Shared package (mem_arb_pkg):
  - State encodings IDLE=2'd0, GRANT_IF=2'd1, GRANT_D=2'd2, TURN=2'd3.
  - Tag constants TAG_IF, TAG_D.
- One sub-module: sat_counter (parameterised width/max, clear, increment), used for the streak counter.
- conflict_cnt is an inline 16-bit wrapping counter.

Test Plan:
1. Reset low for 2 cycles mid-activity → all outputs 0, state IDLE. Then if_req=1, if_addr=0x00, mem holds 0xA5 → if_gnt in the same cycle, next cycle if_rvalid=1 and if_rdata=0xA5.
2. if_req and d_req (load, addr 0x10) both high from cycle 0, MAX_D_STREAK=3 → grants D,D,D,IF,D,D,D,IF. stall_if=1 on the D-grant cycles. conflict_cnt counts every cycle.
3. Store d_addr=0x20, d_wdata=0x3C with WR_TURN=1, if_req=1 throughout → d_gnt cycle, then TURN with no grants, then if_gnt. A later load of 0x20 returns d_rdata=0x3C.
4. Alternating IF reads of 0x01/0x02 every cycle (memory 0x11/0x22) → if_rvalid high every cycle after the first, data 0x11, 0x22 in order. d_rdata unchanged.
5. Read granted, reset asserted in the following cycle before the edge → no rvalid after reset release. rdata registers read 0.
6. conflict_cnt preloaded by forcing 65535 conflict cycles → next conflict cycle wraps it to 0x0000.
